// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the instruction cache: address decode, frame layout, FSM states.
package cpu_types_pkg;

  localparam int unsigned ICACHE_SETS = 16;
  localparam int unsigned IIDX_W      = $clog2(ICACHE_SETS);
  localparam int unsigned ITAG_W      = 32 - IIDX_W - 2;

  // Fetch address split into tag / frame index / ignored byte offset
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  // One direct-mapped frame holding a single instruction word
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Datapath fetch port and memory-control fill port of the instruction cache.
interface icache_if;

  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        ihit;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic [15:0] imiss_count;

  // Datapath + memory-control side
  modport master (
    output imemREN, imemaddr, iflush, iload, iwait,
    input  imemload, ihit, iREN, iaddr, imiss_count
  );

  // Cache side
  modport slave (
    input  imemREN, imemaddr, iflush, iload, iwait,
    output imemload, ihit, iREN, iaddr, imiss_count
  );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a two-state miss FSM.
import cpu_types_pkg::*;

module icache #(
  parameter int unsigned SETS = ICACHE_SETS
) (
  input logic     CLK,
  input logic     nRST,
  icache_if.slave cif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 32 - IDX_W - 2;

  icache_state_t    state, next_state;
  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_arr  [SETS];
  logic [31:0]      data_arr [SETS];
  logic [29:0]      miss_word;
  logic [15:0]      miss_cnt;

  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             hit_c, start_miss_c, fill_done_c, fill_c;
  logic             unused_bytoff;

  // Address decode of the live request and the latched miss word
  assign req_idx       = cif.imemaddr[IDX_W+1:2];
  assign req_tag       = cif.imemaddr[31:IDX_W+2];
  assign miss_idx      = miss_word[IDX_W-1:0];
  assign miss_tag      = miss_word[29:IDX_W];
  assign unused_bytoff = ^cif.imemaddr[1:0];

  // Hit only while idle, never during reset or a flush cycle
  assign hit_c = ~nRST & (state == IDLE) & cif.imemREN & valid[req_idx]
               & (tag_arr[req_idx] == req_tag) & ~cif.iflush;

  // A fill completing together with a flush is discarded
  assign fill_done_c = (state == FILL) & ~cif.iwait & ~cif.iflush;
  assign fill_c      = ~nRST & (state == FILL);

  // Next-state logic; flush always returns to IDLE
  always_comb begin
    next_state   = state;
    start_miss_c = 1'b0;
    case (state)
      IDLE: begin
        if (cif.imemREN && !hit_c && !cif.iflush) begin
          next_state   = FILL;
          start_miss_c = 1'b1;
        end
      end
      FILL: begin
        if (!cif.iwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (cif.iflush) next_state = IDLE;
  end

  // State, valid bits, miss address and saturating miss counter
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state     <= IDLE;
      valid     <= '0;
      miss_word <= '0;
      miss_cnt  <= '0;
    end else begin
      state <= next_state;
      if (start_miss_c) begin
        miss_word <= cif.imemaddr[31:2];
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
      if (cif.iflush)       valid           <= '0;
      else if (fill_done_c) valid[miss_idx] <= 1'b1;
    end
  end

  // Tag and data storage; only the valid bits are ever cleared
  always_ff @(posedge CLK) begin
    if (!nRST && fill_done_c) begin
      tag_arr[miss_idx]  <= miss_tag;
      data_arr[miss_idx] <= cif.iload;
    end
  end

  assign cif.ihit        = hit_c;
  assign cif.imemload    = hit_c ? data_arr[req_idx] : 32'd0;
  assign cif.iREN        = fill_c;
  assign cif.iaddr       = fill_c ? {miss_word, 2'b00} : 32'd0;
  assign cif.imiss_count = miss_cnt;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: vector table of reads plus flush/reset/mid-fill sequences.
module tb_icache;

  logic clk = 1'b0;
  logic rst = 1'b1;

  icache_if cif ();

  icache #(.SETS(16)) dut (
    .CLK (clk),
    .nRST(rst),
    .cif (cif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          hit;
    int          waits;
    logic [31:0] fill;
    logic [31:0] data;
    int          cnt;
  } vec_t;

  vec_t        tbl [11];
  logic [31:0] sb  [$];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // Scoreboard pop: a hit must be present and return the oldest expected word
  task automatic sb_check(input string nm);
    logic [31:0] e;
    n_total++;
    if (cif.ihit !== 1'b1) begin
      $display("FAIL %s: ihit=%b expected 1", nm, cif.ihit);
    end else if (sb.size() == 0) begin
      $display("FAIL %s: hit with empty scoreboard, imemload=0x%08h", nm, cif.imemload);
    end else begin
      e = sb.pop_front();
      if (cif.imemload === e) n_pass++;
      else $display("FAIL %s: imemload=0x%08h expected 0x%08h", nm, cif.imemload, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One read: hit checked same cycle; miss walks the fill and checks the hit after it
  task automatic rd(input vec_t v);
    int rcnt;
    bit addr_bad;
    bit fill_hit;
    rcnt = 0; addr_bad = 0; fill_hit = 0;
    cyc();
    cif.imemREN = 1'b1; cif.imemaddr = v.addr; cif.iwait = 1'b1; cif.iload = v.fill;
    if (v.hit) begin
      sb.push_back(v.data);
      @(negedge clk);
      sb_check("hit_data");
      chk("hit_iren", 32'(cif.iREN), 32'd0);
    end else begin
      @(negedge clk);
      chk("miss_ihit", 32'(cif.ihit), 32'd0);
      for (int c = 0; c <= v.waits; c++) begin
        cyc();
        cif.iwait = (c < v.waits);
        @(negedge clk);
        if (cif.iREN) rcnt++;
        if (cif.iaddr !== {v.addr[31:2], 2'b00}) addr_bad = 1;
        if (cif.ihit) fill_hit = 1;
      end
      chk("fill_iaddr", 32'(addr_bad), 32'd0);
      chk("fill_no_hit", 32'(fill_hit), 32'd0);
      chk("fill_iren_cycles", 32'(rcnt), 32'(v.waits + 1));
      cyc();
      cif.iwait = 1'b1;
      sb.push_back(v.data);
      @(negedge clk);
      sb_check("refill_hit");
      chk("post_fill_iren", 32'(cif.iREN), 32'd0);
    end
    chk("miss_count", 32'(cif.imiss_count), 32'(v.cnt));
    cyc();
    cif.imemREN = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{32'h0000_0040, 1'b0, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
    tbl[1]  = '{32'h0000_0040, 1'b1, 0, 32'h0,         32'hDEAD_BEEF, 1};
    tbl[2]  = '{32'h0000_0440, 1'b0, 1, 32'h0440_1111, 32'h0440_1111, 2};
    tbl[3]  = '{32'h0000_0440, 1'b1, 0, 32'h0,         32'h0440_1111, 2};
    tbl[4]  = '{32'h0000_0040, 1'b0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3};
    tbl[5]  = '{32'h0000_0104, 1'b0, 2, 32'h0104_CAFE, 32'h0104_CAFE, 4};
    tbl[6]  = '{32'h0000_0104, 1'b1, 0, 32'h0,         32'h0104_CAFE, 4};
    tbl[7]  = '{32'h0000_003C, 1'b0, 0, 32'h003C_F00D, 32'h003C_F00D, 5};
    tbl[8]  = '{32'h0000_003C, 1'b1, 0, 32'h0,         32'h003C_F00D, 5};
    tbl[9]  = '{32'h0000_0040, 1'b1, 0, 32'h0,         32'hDEAD_BEEF, 5};
    tbl[10] = '{32'h0000_0106, 1'b1, 0, 32'h0,         32'h0104_CAFE, 5};

    cif.imemREN = 1'b1; cif.imemaddr = 32'h40; cif.iflush = 1'b0;
    cif.iload = 32'h0; cif.iwait = 1'b0;

    // Reset: outputs quiet while asserted and afterwards
    repeat (2) @(negedge clk);
    chk("rst_ihit", 32'(cif.ihit), 32'd0);
    chk("rst_imemload", cif.imemload, 32'd0);
    chk("rst_iren", 32'(cif.iREN), 32'd0);
    chk("rst_iaddr", cif.iaddr, 32'd0);
    cyc();
    rst = 1'b0; cif.imemREN = 1'b0;
    @(negedge clk);
    chk("post_rst_count", 32'(cif.imiss_count), 32'd0);
    chk("post_rst_iren", 32'(cif.iREN), 32'd0);

    for (int i = 0; i < 11; i++) rd(tbl[i]);

    // Flush in IDLE: hit suppressed, no fill started, all frames invalid afterwards
    cyc();
    cif.imemREN = 1'b1; cif.imemaddr = 32'h40; cif.iflush = 1'b1;
    @(negedge clk);
    chk("flush_suppress_hit", 32'(cif.ihit), 32'd0);
    cyc();
    cif.iflush = 1'b0; cif.imemREN = 1'b0;
    @(negedge clk);
    chk("flush_no_fill", 32'(cif.iREN), 32'd0);
    chk("flush_count", 32'(cif.imiss_count), 32'd5);
    rd('{32'h0000_0040, 1'b0, 0, 32'h4040_4040, 32'h4040_4040, 6});
    rd('{32'h0000_0104, 1'b0, 1, 32'h0104_0002, 32'h0104_0002, 7});

    // Address change and request drop mid-fill: latched address completes
    cyc();
    cif.iflush = 1'b1;
    cyc();
    cif.iflush = 1'b0; cif.imemREN = 1'b1; cif.imemaddr = 32'h40;
    cif.iwait = 1'b1; cif.iload = 32'hDEAD_BEEF;
    cyc();
    cif.imemaddr = 32'h80; cif.imemREN = 1'b0;
    @(negedge clk);
    chk("switch_iren", 32'(cif.iREN), 32'd1);
    chk("switch_iaddr", cif.iaddr, 32'h40);
    cyc();
    cif.iwait = 1'b0;
    @(negedge clk);
    chk("switch_iaddr_done", cif.iaddr, 32'h40);
    cyc();
    cif.iwait = 1'b1;
    rd('{32'h0000_0040, 1'b1, 0, 32'h0,         32'hDEAD_BEEF, 8});
    rd('{32'h0000_0080, 1'b0, 1, 32'h8080_8080, 32'h8080_8080, 9});

    // Flush coincident with fill completion: frame stays invalid, read misses again
    cyc();
    cif.imemREN = 1'b1; cif.imemaddr = 32'h40; cif.iwait = 1'b1; cif.iload = 32'h1234_5678;
    cyc();
    @(negedge clk);
    chk("fw_iren", 32'(cif.iREN), 32'd1);
    cyc();
    cif.iwait = 1'b0; cif.iflush = 1'b1;
    @(negedge clk);
    chk("fw_ihit", 32'(cif.ihit), 32'd0);
    cyc();
    cif.iflush = 1'b0; cif.iwait = 1'b1;
    @(negedge clk);
    chk("fw_no_hit", 32'(cif.ihit), 32'd0);
    chk("fw_idle", 32'(cif.iREN), 32'd0);
    cyc();
    @(negedge clk);
    chk("fw_refetch", 32'(cif.iREN), 32'd1);
    cyc();
    cif.iwait = 1'b0; cif.iload = 32'h0000_4444;
    cyc();
    cif.iwait = 1'b1;
    sb.push_back(32'h0000_4444);
    @(negedge clk);
    sb_check("fw_refill_hit");
    chk("fw_count", 32'(cif.imiss_count), 32'd11);
    cyc();
    cif.imemREN = 1'b0;

    // Reset mid-fill: fill aborted, counter cleared, everything misses
    cyc();
    cif.imemREN = 1'b1; cif.imemaddr = 32'h104; cif.iwait = 1'b1;
    cyc();
    @(negedge clk);
    chk("mid_iren", 32'(cif.iREN), 32'd1);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_iren", 32'(cif.iREN), 32'd0);
    chk("mid_rst_iaddr", cif.iaddr, 32'd0);
    chk("mid_rst_ihit", 32'(cif.ihit), 32'd0);
    cyc();
    rst = 1'b0; cif.iwait = 1'b0; cif.imemREN = 1'b0;
    @(negedge clk);
    chk("rst_abort_iren", 32'(cif.iREN), 32'd0);
    chk("rst_abort_count", 32'(cif.imiss_count), 32'd0);
    cif.iwait = 1'b1;
    rd('{32'h0000_0040, 1'b0, 0, 32'h5555_0040, 32'h5555_0040, 1});
    rd('{32'h0000_0104, 1'b0, 0, 32'h5555_0104, 32'h5555_0104, 2});

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter SETS, default 16, number of direct-mapped one-word frames (power of two).
REQ-002 SHALL have port CLK, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port nRST, input, 1, reset: synchronous, active-high (asserted = 1), sampled on CLK.
REQ-004 SHALL have port imemREN, input, 1, datapath instruction read request.
REQ-005 SHALL have port imemaddr, input, 32, datapath fetch byte address (word aligned).
REQ-006 SHALL have port imemload, output, 32, instruction returned to datapath.
REQ-007 SHALL have port ihit, output, 1, imemload valid this cycle.
REQ-008 SHALL have port iflush, input, 1, invalidate all frames.
REQ-009 SHALL have port iREN, output, 1, read request to memory control.
REQ-010 SHALL have port iaddr, output, 32, fill address to memory control.
REQ-011 SHALL have port iload, input, 32, fill data from memory control.
REQ-012 SHALL have port iwait, input, 1, memory control busy; iload valid when iREN=1 and iwait=0.
REQ-013 SHALL have port imiss_count, output, 16, saturating miss counter.

Function
REQ-014 SHALL decode imemaddr as tag [31:2+log2(SETS)], index [1+log2(SETS):2], byte offset [1:0] ignored.
REQ-015 SHALL implement FSM states IDLE and FILL.
REQ-016 In IDLE, ihit SHALL be combinational: imemREN & valid[index] & tag match & ~iflush.
REQ-017 On hit, imemload SHALL equal data[index] in the same cycle; otherwise imemload SHALL be 0.
REQ-018 IDLE->FILL SHALL occur when imemREN & ~hit & ~iflush; imemaddr is latched into a miss register.
REQ-019 In FILL, iREN SHALL be 1 and iaddr SHALL equal the latched address with [1:0]=00; iREN SHALL be 0 in IDLE, and iaddr SHALL be 0 in IDLE.
REQ-020 In FILL with iwait=0, the frame at the latched index SHALL load {valid=1, latched tag, iload} and the FSM SHALL return to IDLE.
REQ-021 Miss latency SHALL be: hit asserted one cycle after the fill-completing cycle (ihit never asserts in FILL).
REQ-022 A change of imemaddr or drop of imemREN during FILL SHALL NOT abort the fill; the latched address completes.
REQ-023 iflush=1 in any state SHALL clear every valid bit at the next edge, abort FILL (next state IDLE), and suppress ihit that cycle.
REQ-024 iflush coincident with fill completion SHALL leave the frame invalid (flush wins).
REQ-025 imiss_count SHALL increment by 1 on each IDLE->FILL transition and saturate at 16'hFFFF.
REQ-026 Tag/data arrays SHALL NOT be cleared by flush; only valid bits.

Reset
REQ-027 nRST=1 at an edge SHALL set state IDLE, all valid bits 0, miss register 0, imiss_count 0.
REQ-028 During and after reset, outputs SHALL be ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-029 Reset asserted mid-FILL SHALL abort the fill with no frame written.

Structure
REQ-030 cpu_types_pkg SHALL hold ICACHE_SETS, IIDX_W, ITAG_W and typedef struct packed icachef_t {tag, idx, bytoff}.
REQ-031 cpu_types_pkg SHALL hold typedef icache_frame_t {valid, tag, data} and enum icache_state_t {IDLE, FILL}.
REQ-032 Block SHALL be flat: no sub-module; frame array and FSM in one module.

Verification
REQ-033 Cold read 0x0000_0040, iwait=1 for 3 cycles then 0, iload=0xDEAD_BEEF -> iREN=1 3+1 cycles, iaddr=0x40, ihit=1 with imemload=0xDEAD_BEEF next cycle, imiss_count=1.
REQ-034 Re-read 0x40 -> ihit=1 same cycle, iREN=0, imiss_count unchanged.
REQ-035 Read 0x0000_0440 (same index, different tag) after 0x40 -> miss, refill, then 0x40 misses again; imiss_count=3.
REQ-036 imemaddr switched 0x40->0x80 mid-FILL -> iaddr stays 0x40, frame 0 filled, then 0x80 misses.
REQ-037 iflush asserted in the cycle iwait falls -> no hit, next read of 0x40 misses; iflush in IDLE -> all prior hits become misses.
REQ-038 nRST pulsed mid-FILL -> iREN=0 next cycle, imiss_count=0, all reads miss.
